uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an AXI-Stream slave port through a small TX FIFO.
// Each frame latches its own divisor, parity mode and stop-bit count when popped.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 17
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          boudrate_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic                          stop_bits_i,
    input  logic [DATA_WIDTH-1:0]         slv_axis_tdata_i,
    input  logic                          slv_axis_tvalid_i,
    input  logic                          slv_axis_tlast_i,
    output logic                          slv_axis_tready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          frame_done_o,
    output logic                          packet_done_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [PTR_W-1:0]     PTR_ONE     = PTR_W'(1);
    localparam logic [LVL_W-1:0]     LVL_ONE     = LVL_W'(1);
    localparam logic [LVL_W-1:0]     LVL_ZERO    = LVL_W'(0);
    localparam logic [LVL_W-1:0]     LVL_DEPTH   = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]     LVL_DEPTH_M = LVL_W'(FIFO_DEPTH - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO    = DIV_WIDTH'(0);
    localparam logic [BIT_W-1:0]     BIT_ZERO    = BIT_W'(0);
    localparam logic [BIT_W-1:0]     BIT_ONE     = BIT_W'(1);
    localparam logic [BIT_W-1:0]     BIT_LAST    = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic [1:0] mode);
        parity_bit = (^data) ^ (mode == 2'b10);
    endfunction

    function automatic logic parity_on(input logic [1:0] mode);
        parity_on = (mode == 2'b01) || (mode == 2'b10);
    endfunction

    logic [DATA_WIDTH:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic                  ready_r;
    state_t                state_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic [DIV_WIDTH-1:0]  baud_r;
    logic [1:0]            par_r;
    logic                  stop2_r;
    logic                  stop_idx_r;
    logic [DIV_WIDTH-1:0]  cnt_r;
    logic [BIT_W-1:0]      bit_idx_r;
    logic                  tx_r;
    logic                  done_r;
    logic                  pkt_r;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   rd_word_s;
    logic [DIV_WIDTH-1:0]  baud_eff_s;

    assign push_s     = slv_axis_tvalid_i & ready_r;
    assign pop_s      = (state_r == IDLE) && (level_r != LVL_ZERO);
    assign rd_word_s  = mem_r[rd_ptr_r];
    assign baud_eff_s = (boudrate_i == DIV_ZERO) ? DIV_ONE : boudrate_i;

    // FIFO storage array, written on every accepted beat.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {slv_axis_tlast_i, slv_axis_tdata_i};
        end
    end

    // FIFO pointers, occupancy and registered tready (kept equal to level < depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10: begin
                    level_r <= level_r + LVL_ONE;
                    ready_r <= (level_r < LVL_DEPTH_M);
                end
                2'b01: begin
                    level_r <= level_r - LVL_ONE;
                    ready_r <= 1'b1;
                end
                default: begin
                    ready_r <= (level_r < LVL_DEPTH);
                end
            endcase
        end
    end

    // Frame FSM; tx_r follows the state one clock later, so done pulses land on the last stop clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            data_r     <= {DATA_WIDTH{1'b0}};
            last_r     <= 1'b0;
            baud_r     <= DIV_ONE;
            par_r      <= 2'b00;
            stop2_r    <= 1'b0;
            stop_idx_r <= 1'b0;
            cnt_r      <= DIV_ZERO;
            bit_idx_r  <= BIT_ZERO;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            pkt_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            pkt_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        data_r     <= rd_word_s[DATA_WIDTH-1:0];
                        last_r     <= rd_word_s[DATA_WIDTH];
                        baud_r     <= baud_eff_s;
                        par_r      <= parity_mode_i;
                        stop2_r    <= stop_bits_i;
                        stop_idx_r <= 1'b0;
                        cnt_r      <= baud_eff_s - DIV_ONE;
                        state_r    <= START;
                    end
                end
                START: begin
                    tx_r <= 1'b0;
                    if (cnt_r == DIV_ZERO) begin
                        cnt_r     <= baud_r - DIV_ONE;
                        bit_idx_r <= BIT_ZERO;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                DATA: begin
                    tx_r <= data_r[bit_idx_r];
                    if (cnt_r == DIV_ZERO) begin
                        cnt_r <= baud_r - DIV_ONE;
                        if (bit_idx_r == BIT_LAST) begin
                            state_r <= parity_on(par_r) ? PARITY : STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                PARITY: begin
                    tx_r <= parity_bit(data_r, par_r);
                    if (cnt_r == DIV_ZERO) begin
                        cnt_r   <= baud_r - DIV_ONE;
                        state_r <= STOP;
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (cnt_r == DIV_ZERO) begin
                        if (stop2_r && !stop_idx_r) begin
                            stop_idx_r <= 1'b1;
                            cnt_r      <= baud_r - DIV_ONE;
                        end else begin
                            done_r  <= 1'b1;
                            pkt_r   <= last_r;
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign slv_axis_tready_o = ready_r;
    assign tx_o              = tx_r;
    assign busy_o            = (state_r != IDLE) || (level_r != LVL_ZERO);
    assign fifo_level_o      = level_r;
    assign frame_done_o      = done_r;
    assign packet_done_o     = pkt_r;

endmodule
